// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash,
// memory-stall freeze and saturating bubble/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [10:0]       id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_funct,
    input  logic              ex_flush,
    input  logic              mem_stall,
    output logic              ex_valid,
    output logic [10:0]       ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [3:0]        ex_funct,
    output logic              stall_front,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q, valid_d;
    logic [10:0]       ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]        funct_q, funct_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              lu_haz;

    // rs2 is compared even for I-type: a spurious bubble is cheaper than decode here.
    always_comb begin
        lu_haz = valid_q & ctrl_q[7] & (rd_q != '0) & id_valid
                 & ((rd_q == id_rs1) | (rd_q == id_rs2));
    end

    assign stall_front = mem_stall | (lu_haz & ~ex_flush);

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        funct_d      = funct_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!mem_stall) begin
            if (ex_flush || lu_haz) begin
                // Bubble: all-zero control guarantees no RegWrite/MemWrite side effect.
                valid_d = 1'b0;
                ctrl_d  = '0;
                pc_d    = '0;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                rs1_d   = '0;
                rs2_d   = '0;
                rd_d    = '0;
                funct_d = '0;
                if (ex_flush) begin
                    if (id_valid && flush_cnt_q != CNT_MAX)
                        flush_cnt_d = flush_cnt_q + 1'b1;
                end else if (bubble_cnt_q != CNT_MAX) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                valid_d = id_valid;
                ctrl_d  = id_valid ? id_ctrl : '0;
                pc_d    = id_pc;
                rd1_d   = id_rd1;
                rd2_d   = id_rd2;
                imm_d   = id_imm;
                rs1_d   = id_rs1;
                rs2_d   = id_rs2;
                rd_d    = id_rd;
                funct_d = id_funct;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            pc_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            funct_q      <= funct_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc      = pc_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm     = imm_q;
    assign ex_rs1     = rs1_q;
    assign ex_rs2     = rs2_q;
    assign ex_rd      = rd_q;
    assign ex_funct   = funct_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic against
// an instruction-level reference model of the EX slot.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0, reset = 1'b1;
    logic              id_valid = 1'b0, ex_flush = 1'b0, mem_stall = 1'b0;
    logic [10:0]       id_ctrl = '0;
    logic [DATA_W-1:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]        id_funct = '0;
    logic              ex_valid, stall_front;
    logic [10:0]       ex_ctrl;
    logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]        ex_funct;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
        .ex_flush(ex_flush), .mem_stall(mem_stall), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct(ex_funct), .stall_front(stall_front),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Instruction occupying the EX slot, as the model sees it.
    typedef struct {
        bit          valid;
        bit   [10:0] ctrl;
        bit   [31:0] pc, rd1, rd2, imm;
        bit   [4:0]  rs1, rs2, rd;
        bit   [3:0]  funct;
    } instr_t;

    instr_t m_ex, empty_ex;
    int     m_bub, m_fl;
    int     checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_haz();
        bit is_load = m_ex.valid && m_ex.ctrl[7];
        bit reads_it = (m_ex.rd == id_rs1) || (m_ex.rd == id_rs2);
        return is_load && m_ex.rd != 0 && id_valid && reads_it;
    endfunction

    task automatic model_reset();
        m_ex  = empty_ex;
        m_bub = 0;
        m_fl  = 0;
    endtask

    task automatic cmp_all(input string ph);
        chk({ph, "_valid"}, ex_valid, m_ex.valid);
        chk({ph, "_ctrl"}, ex_ctrl, m_ex.ctrl);
        chk({ph, "_pc"}, ex_pc, m_ex.pc);
        chk({ph, "_rd1"}, ex_rd1, m_ex.rd1);
        chk({ph, "_rd2"}, ex_rd2, m_ex.rd2);
        chk({ph, "_imm"}, ex_imm, m_ex.imm);
        chk({ph, "_idx"}, {ex_rs1, ex_rs2, ex_rd, ex_funct}, {m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.funct});
        chk({ph, "_bub"}, bubble_cnt, m_bub);
        chk({ph, "_fl"}, flush_cnt, m_fl);
    endtask

    // Called with inputs settled mid-cycle: checks stall, clocks, advances model.
    task automatic tick(input string ph);
        bit haz = model_haz();
        chk({ph, "_stall"}, stall_front, mem_stall || (haz && !ex_flush));
        @(posedge clk);
        if (mem_stall) begin
        end else if (ex_flush) begin
            m_ex = empty_ex;
            if (id_valid) m_fl = (m_fl < CMAX) ? m_fl + 1 : CMAX;
        end else if (haz) begin
            m_ex  = empty_ex;
            m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end else begin
            m_ex.valid = id_valid;
            m_ex.ctrl  = id_valid ? id_ctrl : 11'h0;
            m_ex.pc    = id_pc;   m_ex.rd1 = id_rd1; m_ex.rd2 = id_rd2; m_ex.imm = id_imm;
            m_ex.rs1   = id_rs1;  m_ex.rs2 = id_rs2; m_ex.rd  = id_rd;  m_ex.funct = id_funct;
        end
        #1 cmp_all(ph);
    endtask

    task automatic set_id(input bit v, input logic [10:0] c, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd);
        id_valid = v; id_ctrl = c; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
        id_funct = 4'($urandom);
    endtask

    localparam logic [10:0] LW  = 11'h590; // ALUSrc|MemtoReg|RegWrite|MemRead
    localparam logic [10:0] ADD = 11'h120; // RegWrite|ALUOp=10

    initial begin
        logic [31:0] hold_pc;
        empty_ex = '{default: 0};
        model_reset();
        #12 reset = 1'b0;
        #1 cmp_all("rst0");

        // Pass-through
        @(negedge clk); set_id(1, 11'h4A1, 1, 2, 5); id_pc = 32'h100;
        #1 chk("pt_stall_pre", stall_front, 0);
        tick("pt");
        chk("pt_ctrl", ex_ctrl, 11'h4A1); chk("pt_pc", ex_pc, 32'h100);
        chk("pt_rd", ex_rd, 5); chk("pt_valid", ex_valid, 1);

        // Load-use: lw x5 then add rs1=5
        @(negedge clk); set_id(1, LW, 1, 2, 5); #1 tick("lu_ld");
        @(negedge clk); set_id(1, ADD, 5, 6, 7);
        #1 chk("lu_stall", stall_front, 1);
        tick("lu_bub");
        chk("lu_bub_valid", ex_valid, 0); chk("lu_bub_cnt", bubble_cnt, 1);
        #3 chk("lu_stall_clr", stall_front, 0);
        tick("lu_adv");
        chk("lu_adv_rd", ex_rd, 7); chk("lu_adv_valid", ex_valid, 1);

        // Load to x0 never stalls
        @(negedge clk); set_id(1, LW, 1, 2, 0); #1 tick("x0_ld");
        @(negedge clk); set_id(1, ADD, 0, 0, 8);
        #1 chk("x0_stall", stall_front, 0);
        tick("x0_add");

        // mem_stall with flush and hazard pending, then flush beats hazard on release
        @(negedge clk); set_id(1, LW, 1, 2, 9); #1 tick("ms_ld");
        hold_pc = ex_pc;
        @(negedge clk); set_id(1, ADD, 3, 9, 10); ex_flush = 1; mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ms_stall", stall_front, 1);
            tick("ms_hold");
            chk("ms_pc_held", ex_pc, hold_pc);
            @(negedge clk);
        end
        mem_stall = 0;
        #1 chk("fh_stall", stall_front, 0);
        tick("fh");
        chk("fh_valid", ex_valid, 0); chk("fh_flcnt", flush_cnt, 1);
        chk("fh_bubcnt", bubble_cnt, 1);
        ex_flush = 0;

        // Async reset mid-cycle with a valid instruction in EX
        @(negedge clk); set_id(1, LW, 1, 2, 4); #1 tick("ar_ld");
        #2 reset = 1;
        #1 model_reset();
        chk("ar_valid", ex_valid, 0); chk("ar_ctrl", ex_ctrl, 0);
        chk("ar_cnts", {bubble_cnt, flush_cnt}, 0);
        #1 reset = 0;

        // Saturation: more hazards than the counter can hold
        for (int i = 0; i < CMAX + 2; i++) begin
            @(negedge clk); set_id(1, LW, 1, 2, 3); #1 tick("sat_ld");
            @(negedge clk); set_id(1, ADD, 3, 1, 2); #1 tick("sat_bub");
            @(negedge clk); #1 tick("sat_adv");
        end
        chk("sat_bub_cnt", bubble_cnt, CMAX);

        // Randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            set_id(($urandom_range(0, 9) != 0), 11'($urandom) | (($urandom_range(0, 1) != 0) ? LW : 11'h0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            ex_flush  = ($urandom_range(0, 7) == 0);
            mem_stall = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1;
                #1 model_reset();
                cmp_all("rnd_rst");
                reset = 0;
            end else begin
                #1;
            end
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
